// File: rtl/bsg_gateway_reset_seq_pkg.sv
// Shared types and constants for the gateway reset sequencer.
package bsg_gateway_reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int lock_loss_count_width_lp = 8;

endpackage

// File: rtl/bsg_gateway_sync.sv
// N-stage single-bit synchronizer for an asynchronous level input.
module bsg_gateway_sync #(
    parameter int stages_p = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [stages_p-1:0] sync_reg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[stages_p-2:0], d_i};
        end
    end

    assign q_o = sync_reg[stages_p-1];

endmodule

// File: rtl/bsg_gateway_reset_seq.sv
// Staged domain-reset sequencer: waits for a continuously stable clock lock,
// then releases resets one at a time in index order.
module bsg_gateway_reset_seq
    import bsg_gateway_reset_seq_pkg::*;
#(
    parameter int sync_stages_p        = 2,
    parameter int lock_stable_cycles_p = 1024,
    parameter int stage_gap_cycles_p   = 64,
    parameter int num_resets_p         = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                locked_i,
    input  logic                                sw_reset_i,
    output logic [num_resets_p-1:0]             reset_o,
    output logic                                all_ready_o,
    output logic [lock_loss_count_width_lp-1:0] lock_loss_count_o,
    output logic [1:0]                          state_o
);

    localparam int max_cycles_lp = (lock_stable_cycles_p > stage_gap_cycles_p)
                                   ? lock_stable_cycles_p : stage_gap_cycles_p;
    localparam int cnt_w_lp = $clog2(max_cycles_lp + 1);
    localparam int idx_w_lp = (num_resets_p > 1) ? $clog2(num_resets_p) : 1;

    localparam logic [cnt_w_lp-1:0] lock_last_lp = cnt_w_lp'(lock_stable_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] gap_last_lp  = cnt_w_lp'(stage_gap_cycles_p - 1);
    localparam logic [idx_w_lp-1:0] idx_last_lp  = idx_w_lp'(num_resets_p - 1);

    logic locked_s;

    state_e                          state_reg, state_next;
    logic [cnt_w_lp-1:0]             cnt_reg, cnt_next;
    logic [idx_w_lp-1:0]             idx_reg, idx_next;
    logic [num_resets_p-1:0]         rst_reg, rst_next;
    logic                            ready_reg, ready_next;
    logic [lock_loss_count_width_lp-1:0] loss_reg, loss_next;

    bsg_gateway_sync #(
        .stages_p(sync_stages_p)
    ) lock_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (locked_i),
        .q_o    (locked_s)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            rst_reg   <= '1;
            ready_reg <= 1'b0;
            loss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            rst_reg   <= rst_next;
            ready_reg <= ready_next;
            loss_reg  <= loss_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        rst_next   = rst_reg;
        ready_next = ready_reg;
        loss_next  = loss_reg;

        case (state_reg)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (locked_s) begin
                    state_next = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == lock_last_lp) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt_reg + cnt_w_lp'(1);
                end
            end
            default: begin // RELEASE and RUN share the abort paths
                // Lock loss takes priority over a software request.
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                    idx_next   = '0;
                    rst_next   = '1;
                    ready_next = 1'b0;
                    if (loss_reg != '1) begin
                        loss_next = loss_reg + lock_loss_count_width_lp'(1);
                    end
                end else if (sw_reset_i) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                    rst_next   = '1;
                    ready_next = 1'b0;
                end else if (state_reg == RELEASE) begin
                    if (cnt_reg == gap_last_lp) begin
                        cnt_next = '0;
                        for (int i = 0; i < num_resets_p; i++) begin
                            if (idx_reg == idx_w_lp'(i)) begin
                                rst_next[i] = 1'b0;
                            end
                        end
                        if (idx_reg == idx_last_lp) begin
                            state_next = RUN;
                            ready_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + idx_w_lp'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + cnt_w_lp'(1);
                    end
                end
            end
        endcase
    end

    assign reset_o           = rst_reg;
    assign all_ready_o       = ready_reg;
    assign lock_loss_count_o = loss_reg;
    assign state_o           = state_reg;

endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// Bench for bsg_gateway_reset_seq: timestamp-based reference model plus
// directed scenarios with hard-coded edge expectations and random lock/sw traffic.
module tb_bsg_gateway_reset_seq;

    localparam int N  = 2;
    localparam int L  = 16;
    localparam int G  = 4;
    localparam int NR = 4;

    logic          clk;
    logic          reset_i;
    logic          locked_i;
    logic          sw_reset_i;
    logic [NR-1:0] reset_o;
    logic          all_ready_o;
    logic [7:0]    lock_loss_count_o;
    logic [1:0]    state_o;

    int total = 0;
    int bad   = 0;

    // Reference model: lock history delay line, consecutive-lock run length,
    // and the edge at which the current release sequence started.
    int t;
    int t0;
    int run;
    int loss;
    bit released;
    bit lq[$];

    bsg_gateway_reset_seq #(
        .sync_stages_p       (N),
        .lock_stable_cycles_p(L),
        .stage_gap_cycles_p  (G),
        .num_resets_p        (NR)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .locked_i         (locked_i),
        .sw_reset_i       (sw_reset_i),
        .reset_o          (reset_o),
        .all_ready_o      (all_ready_o),
        .lock_loss_count_o(lock_loss_count_o),
        .state_o          (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        t = -1;
        t0 = 0;
        run = 0;
        loss = 0;
        released = 1'b0;
        lq.delete();
        for (int i = 0; i < N; i++) lq.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit ls;
        t = t + 1;
        ls = lq.pop_front();
        lq.push_back(locked_i);
        if (!released) begin
            run = ls ? run + 1 : 0;
            if (run == L + 1) begin
                released = 1'b1;
                t0 = t;
            end
        end else if (!ls) begin
            released = 1'b0;
            run = 0;
            if (loss < 255) loss = loss + 1;
        end else if (sw_reset_i) begin
            t0 = t;
        end
    endtask

    function automatic logic [NR-1:0] exp_reset();
        logic [NR-1:0] r;
        r = '1;
        if (released) begin
            for (int k = 0; k < NR; k++) begin
                if (t - t0 >= (k + 1) * G) r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic exp_ready();
        return released && (t - t0 >= NR * G);
    endfunction

    function automatic logic [1:0] exp_state();
        if (released) return exp_ready() ? 2'd3 : 2'd2;
        return (run > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic check_model(input string tag);
        logic [NR-1:0] er;
        logic [1:0]    es;
        logic          ey;
        er = exp_reset();
        es = exp_state();
        ey = exp_ready();
        total++;
        assert (reset_o === er) else begin
            bad++;
            $error("FAIL %s reset_o got %h want %h (edge %0d)", tag, reset_o, er, t);
        end
        total++;
        assert (all_ready_o === ey) else begin
            bad++;
            $error("FAIL %s all_ready_o got %b want %b (edge %0d)", tag, all_ready_o, ey, t);
        end
        total++;
        assert (lock_loss_count_o === 8'(loss)) else begin
            bad++;
            $error("FAIL %s lock_loss_count_o got %0d want %0d (edge %0d)", tag, lock_loss_count_o, loss, t);
        end
        total++;
        assert (state_o === es) else begin
            bad++;
            $error("FAIL %s state_o got %0d want %0d (edge %0d)", tag, state_o, es, t);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        locked_i = 1'b0;
        sw_reset_i = 1'b0;
        model_reset();
        #1;
        check_model("reset_values");
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Lock goes high before E0 from WAIT_LOCK with a cleared synchronizer.
    task automatic release_timing(input string tag);
        logic [NR-1:0] want;
        locked_i = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            tick(tag);
            want = 4'hF;
            for (int k = 0; k < NR; k++) begin
                if (e >= 22 + 4 * k) want[k] = 1'b0;
            end
            check_val({tag, "_reset_const"}, 32'(reset_o), 32'(want));
            if (e == 33) check_val({tag, "_ready_e33"}, 32'(all_ready_o), 32'd0);
            if (e == 34) begin
                check_val({tag, "_ready_e34"}, 32'(all_ready_o), 32'd1);
                check_val({tag, "_state_e34"}, 32'(state_o), 32'd3);
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        locked_i = 1'b0;
        sw_reset_i = 1'b0;
        model_reset();

        // 1: power-up release timing
        do_reset();
        release_timing("powerup");
        $display("scenario powerup: reset_o=%h ready=%b state=%0d", reset_o, all_ready_o, state_o);

        // 4: software re-release from RUN
        sw_reset_i = 1'b1;
        tick("sw_pulse");
        sw_reset_i = 1'b0;
        check_val("sw_reassert", 32'(reset_o), 32'hF);
        for (int e = 1; e <= 20; e++) begin
            tick("sw_release");
            if (e == 3)  check_val("sw_bit0_held", 32'(reset_o[0]), 32'd1);
            if (e == 4)  check_val("sw_bit0_fall", 32'(reset_o), 32'hE);
            if (e == 16) check_val("sw_all_fall", 32'(reset_o), 32'h0);
        end
        check_val("sw_count", 32'(lock_loss_count_o), 32'd0);
        $display("scenario sw_reset: reset_o=%h count=%0d", reset_o, lock_loss_count_o);

        // 3: lock loss in RUN, then relock
        locked_i = 1'b0;
        tick("loss_e0");
        tick("loss_e1");
        check_val("loss_e1_reset", 32'(reset_o), 32'h0);
        tick("loss_e2");
        check_val("loss_e2_reset", 32'(reset_o), 32'hF);
        check_val("loss_e2_ready", 32'(all_ready_o), 32'd0);
        check_val("loss_e2_count", 32'(lock_loss_count_o), 32'd1);
        repeat (3) tick("loss_low");
        release_timing("relock");
        $display("scenario lock_loss_run: count=%0d state=%0d", lock_loss_count_o, state_o);

        // 5: sw request and lock loss seen in the same cycle during RELEASE
        sw_reset_i = 1'b1;
        tick("sim_pre_sw");
        sw_reset_i = 1'b0;
        repeat (5) tick("sim_release");
        locked_i = 1'b0;
        tick("sim_e0");
        tick("sim_e1");
        sw_reset_i = 1'b1;
        tick("sim_e2");
        sw_reset_i = 1'b0;
        check_val("sim_state", 32'(state_o), 32'd0);
        check_val("sim_count", 32'(lock_loss_count_o), 32'd2);
        repeat (3) tick("sim_low");
        locked_i = 1'b1;
        for (int e = 0; e < 18; e++) tick("sim_requal");
        check_val("sim_no_early_release", 32'(state_o), 32'd1);
        tick("sim_requal_done");
        check_val("sim_release_e18", 32'(state_o), 32'd2);
        $display("scenario sim_events: count=%0d state=%0d", lock_loss_count_o, state_o);

        // random lock chatter and sw requests against the model
        for (int b = 0; b < 120; b++) begin
            locked_i = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 40)) begin
                sw_reset_i = ($urandom_range(0, 19) == 0);
                tick("random");
            end
        end
        sw_reset_i = 1'b0;
        $display("random phase: count=%0d state=%0d", lock_loss_count_o, state_o);

        // 2: lock chatter before qualification
        do_reset();
        locked_i = 1'b1;
        repeat (10) tick("chatter_high");
        locked_i = 1'b0;
        repeat (4) tick("chatter_low");
        check_val("chatter_state", 32'(state_o), 32'd0);
        check_val("chatter_reset", 32'(reset_o), 32'hF);
        check_val("chatter_count", 32'(lock_loss_count_o), 32'd0);
        $display("scenario chatter: reset_o=%h state=%0d", reset_o, state_o);

        // 6: saturation, then asynchronous reset mid-RELEASE
        for (int i = 0; i < 300; i++) begin
            locked_i = 1'b1;
            repeat (20 + $urandom_range(0, 15)) tick("sat_high");
            locked_i = 1'b0;
            repeat ($urandom_range(1, 3)) tick("sat_low");
        end
        repeat (3) tick("sat_settle");
        check_val("sat_count", 32'(lock_loss_count_o), 32'd255);
        locked_i = 1'b1;
        repeat (20) tick("sat_relock");
        check_val("sat_in_release", 32'(state_o), 32'd2);
        #2;
        reset_i = 1'b1;
        #1;
        check_val("async_reset_o", 32'(reset_o), 32'hF);
        check_val("async_ready", 32'(all_ready_o), 32'd0);
        check_val("async_count", 32'(lock_loss_count_o), 32'd0);
        check_val("async_state", 32'(state_o), 32'd0);
        $display("scenario saturation: async reset reset_o=%h count=%0d", reset_o, lock_loss_count_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
